// File: rtl/axi4_stream_dly_smp.sv
// rtl/axi4_stream_dly_smp.sv - runtime-programmable whole-sample delay for one AXI4-Stream
module axi4_stream_dly_smp #(
  parameter int DN = 1,
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               ctl_rst,
  input  logic [AW-1:0]      cfg_dly,
  output logic [AW-1:0]      sts_dly,
  output logic [AW:0]        sts_fill,
  input  logic [DN*DW-1:0]   sti_TDATA,
  input  logic [DN-1:0]      sti_TKEEP,
  input  logic               sti_TLAST,
  input  logic               sti_TVALID,
  output logic               sti_TREADY,
  output logic [DN*DW-1:0]   sto_TDATA,
  output logic [DN-1:0]      sto_TKEEP,
  output logic               sto_TLAST,
  output logic               sto_TVALID,
  input  logic               sto_TREADY
);

  // Payload word layout: {TDATA, TKEEP, TLAST}
  localparam int          PW       = DN*DW + DN + 1;
  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] in_pl;
  logic [PW-1:0] sel_pl;
  logic [PW-1:0] out_pl;
  logic          xi;

  // Ready depends only on the output register and downstream ready, never on sti_TVALID
  assign sti_TREADY = ~ctl_rst & (~sto_TVALID | sto_TREADY);
  assign xi         = sti_TVALID & sti_TREADY;
  assign in_pl      = {sti_TDATA, sti_TKEEP, sti_TLAST};
  assign rd_addr    = wp - sts_dly;

  assign {sto_TDATA, sto_TKEEP, sto_TLAST} = out_pl;

  // Pick the word to present: bypass for D=0, history once D words exist, zeros before that
  always_comb begin
    sel_pl = '0;
    if (sts_dly == '0) begin
      sel_pl = in_pl;
    end else if (sts_fill >= {1'b0, sts_dly}) begin
      sel_pl = mem[rd_addr];
    end
  end

  // History buffer write; contents are deliberately left unreset
  always_ff @(posedge ACLK) begin
    if (xi) begin
      mem[wp] <= in_pl;
    end
  end

  // Control, pointer, fill count and the registered output stage
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sts_dly    <= '0;
      sts_fill   <= '0;
      wp         <= '0;
      sto_TVALID <= 1'b0;
      out_pl     <= '0;
    end else if (ctl_rst) begin
      sts_dly    <= cfg_dly;
      sts_fill   <= '0;
      wp         <= '0;
      sto_TVALID <= 1'b0;
    end else if (xi) begin
      wp         <= wp + 1'b1;
      if (sts_fill != FILL_MAX) begin
        sts_fill <= sts_fill + 1'b1;
      end
      sto_TVALID <= 1'b1;
      out_pl     <= sel_pl;
    end else if (sto_TREADY) begin
      sto_TVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_stream_dly_smp.sv
// tb/tb_axi4_stream_dly_smp.sv - scoreboard bench for the stream sample delay
module tb_axi4_stream_dly_smp;

  localparam int DN    = 2;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int PW    = DN*DW + DN + 1;
  localparam int DEPTH = 1 << AW;

  logic               ACLK = 1'b0;
  logic               ARESETn = 1'b0;
  logic               ctl_rst = 1'b0;
  logic [AW-1:0]      cfg_dly = '0;
  logic [AW-1:0]      sts_dly;
  logic [AW:0]        sts_fill;
  logic [DN*DW-1:0]   sti_TDATA = '0;
  logic [DN-1:0]      sti_TKEEP = '0;
  logic               sti_TLAST = 1'b0;
  logic               sti_TVALID = 1'b0;
  logic               sti_TREADY;
  logic [DN*DW-1:0]   sto_TDATA;
  logic [DN-1:0]      sto_TKEEP;
  logic               sto_TLAST;
  logic               sto_TVALID;
  logic               sto_TREADY = 1'b0;

  axi4_stream_dly_smp #(.DN(DN), .DW(DW), .AW(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .ctl_rst(ctl_rst), .cfg_dly(cfg_dly),
    .sts_dly(sts_dly), .sts_fill(sts_fill),
    .sti_TDATA(sti_TDATA), .sti_TKEEP(sti_TKEEP), .sti_TLAST(sti_TLAST),
    .sti_TVALID(sti_TVALID), .sti_TREADY(sti_TREADY),
    .sto_TDATA(sto_TDATA), .sto_TKEEP(sto_TKEEP), .sto_TLAST(sto_TLAST),
    .sto_TVALID(sto_TVALID), .sto_TREADY(sto_TREADY)
  );

  always #5 ACLK = ~ACLK;

  int            n_chk = 0;
  int            n_fail = 0;
  int            mdly = 0;
  logic [PW-1:0] hist [$];
  logic [PW-1:0] exp_q [$];
  bit            stall_prev = 1'b0;
  logic [PW-1:0] stall_pl;
  logic [PW-1:0] mon_pl;
  bit            acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: output k is input k-D of the current run, zero payload while fewer than D exist
  task automatic model_accept();
    logic [PW-1:0] p;
    logic [PW-1:0] e;
    p = {sti_TDATA, sti_TKEEP, sti_TLAST};
    if (mdly == 0)                e = p;
    else if (hist.size() >= mdly) e = hist[hist.size() - mdly];
    else                          e = '0;
    exp_q.push_back(e);
    hist.push_back(p);
  endtask

  // Monitor: compare every completed output transfer and check payload holds under stall
  always @(negedge ACLK) begin
    if (ARESETn) begin
      mon_pl = {sto_TDATA, sto_TKEEP, sto_TLAST};
      if (stall_prev) begin
        chk("stall_valid", 32'(sto_TVALID), 32'd1);
        chk("stall_payload", 32'(mon_pl), 32'(stall_pl));
      end
      if (sto_TVALID && sto_TREADY) begin
        chk("output_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("payload", 32'(mon_pl), 32'(exp_q.pop_front()));
      end
      stall_prev = sto_TVALID && !sto_TREADY && !ctl_rst;
      stall_pl   = mon_pl;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // One clock: called at posedge+1, returns at the next posedge+1
  task automatic step(input bit rdy, output bit a);
    bit was_rst;
    sto_TREADY = rdy;
    @(negedge ACLK);
    chk("tready_rule", 32'(sti_TREADY), 32'(!ctl_rst && (!sto_TVALID || sto_TREADY)));
    a       = sti_TVALID && sti_TREADY;
    was_rst = ctl_rst;
    if (a) model_accept();
    if (was_rst) begin
      mdly = int'(cfg_dly);
      hist.delete();
      exp_q.delete();
    end
    @(posedge ACLK);
    #1;
    if (a) chk("valid_after_accept", 32'(sto_TVALID), 32'd1);
    if (was_rst) chk("valid_after_clear", 32'(sto_TVALID), 32'd0);
    chk("sts_dly", 32'(sts_dly), 32'(mdly));
    chk("sts_fill", 32'(sts_fill), 32'((hist.size() < DEPTH) ? hist.size() : DEPTH));
  endtask

  task automatic clear(input int d);
    bit a;
    ctl_rst = 1'b1;
    cfg_dly = AW'(d);
    step(1'b0, a);
    ctl_rst = 1'b0;
    cfg_dly = AW'($urandom);
  endtask

  task automatic send(input logic [DN*DW-1:0] d, input logic [DN-1:0] k, input logic l,
                      input bit gaps, input bit rnd);
    bit a;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        sti_TVALID = 1'b0;
        step(rnd ? 1'($urandom) : 1'b1, a);
      end
    end
    sti_TDATA  = d;
    sti_TKEEP  = k;
    sti_TLAST  = l;
    sti_TVALID = 1'b1;
    a = 1'b0;
    for (int t = 0; t < 60 && !a; t++) step(rnd ? 1'($urandom) : 1'b1, a);
    chk("accept_timeout", 32'(a), 32'd1);
  endtask

  task automatic drain();
    bit a;
    sti_TVALID = 1'b0;
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) step(1'b1, a);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_valid", 32'(sto_TVALID), 32'd0);
    chk("rst_data", 32'({sto_TDATA, sto_TKEEP, sto_TLAST}), 32'd0);
    chk("rst_dly", 32'(sts_dly), 32'd0);
    chk("rst_fill", 32'(sts_fill), 32'd0);
    #2 ARESETn = 1'b1;
    @(posedge ACLK);
    #1;

    // D=3, continuous stream
    clear(3);
    for (int i = 1; i <= 10; i++) send(16'(i), 2'b11, 1'b0, 1'b0, 1'b0);
    drain();

    // D=0 bypass with TLAST on the fifth word
    clear(0);
    for (int i = 1; i <= 5; i++) send(16'(16'h100 + i), 2'b01, i == 5, 1'b0, 1'b0);
    drain();
    chk("fill_five", 32'(sts_fill), 32'd5);

    // D=2 with random gaps and backpressure
    clear(2);
    for (int i = 0; i < 60; i++) send(16'($urandom), 2'($urandom), 1'($urandom), 1'b1, 1'b1);
    drain();

    // Maximum delay, pointer wraps twice, fill saturates
    clear(DEPTH - 1);
    for (int i = 0; i < 40; i++) send(16'($urandom), 2'($urandom), 1'($urandom), 1'b0, 1'b0);
    drain();
    chk("fill_sat", 32'(sts_fill), 32'(DEPTH));

    // Clear with a word presented and an output pending
    clear(4);
    for (int i = 0; i < 10; i++) send(16'(16'h200 + i), 2'b10, 1'b0, 1'b0, 1'b0);
    sti_TDATA  = 16'hBEEF;
    sti_TVALID = 1'b1;
    ctl_rst    = 1'b1;
    cfg_dly    = AW'(1);
    step(1'b0, acc);
    chk("clear_blocks_input", 32'(acc), 32'd0);
    ctl_rst = 1'b0;
    cfg_dly = AW'(9);
    for (int i = 0; i < 3; i++) send(16'(16'h300 + i), 2'b11, 1'b0, 1'b0, 1'b0);
    drain();
    chk("dly_one", 32'(sts_dly), 32'd1);

    // Asynchronous reset mid-stream, then D=0 behaviour
    for (int i = 0; i < 4; i++) send(16'(16'h400 + i), 2'b11, 1'b0, 1'b0, 1'b0);
    sti_TVALID = 1'b0;
    #2 ARESETn = 1'b0;
    #1;
    chk("arst_valid", 32'(sto_TVALID), 32'd0);
    chk("arst_dly", 32'(sts_dly), 32'd0);
    chk("arst_fill", 32'(sts_fill), 32'd0);
    mdly = 0;
    hist.delete();
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge ACLK);
    #3 ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    for (int i = 0; i < 8; i++) send(16'($urandom), 2'($urandom), 1'($urandom), 1'b1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
